// File: rtl/mem_d_arbiter.sv
// N-master arbiter for the TCM data port with held grants and an in-order ID FIFO for response routing.
// Optional ARB_LOCK_EN adds m_lock_i so a master can keep exclusive ownership across a read-modify-write.
module mem_d_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int TAG_W       = 11,
  parameter int OUTSTANDING = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       mode_rr_i,
  input  logic [NUM_MASTERS*32-1:0]  m_addr_i,
  input  logic [NUM_MASTERS*32-1:0]  m_data_wr_i,
  input  logic [NUM_MASTERS-1:0]     m_rd_i,
  input  logic [NUM_MASTERS*4-1:0]   m_wr_i,
  input  logic [NUM_MASTERS*TAG_W-1:0] m_tag_i,
`ifdef ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0]     m_lock_i,
`endif
  output logic [NUM_MASTERS-1:0]     m_accept_o,
  output logic [NUM_MASTERS-1:0]     m_ack_o,
  output logic [NUM_MASTERS-1:0]     m_error_o,
  output logic [31:0]                m_data_rd_o,
  output logic [TAG_W-1:0]           m_resp_tag_o,
  output logic [31:0]                mem_addr_o,
  output logic [31:0]                mem_data_wr_o,
  output logic                       mem_rd_o,
  output logic [3:0]                 mem_wr_o,
  output logic [TAG_W-1:0]           mem_req_tag_o,
  input  logic                       mem_accept_i,
  input  logic                       mem_ack_i,
  input  logic                       mem_error_i,
  input  logic [31:0]                mem_data_rd_i,
  input  logic [TAG_W-1:0]           mem_resp_tag_i,
  output logic [$clog2(OUTSTANDING):0] outstanding_o,
  output logic                       unexpected_ack_o
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] elig;
  logic                   grant_vld;
  logic [IDX_W-1:0]       grant_idx;
  logic                   issue;
  logic                   accept;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [IDX_W-1:0]       head;
  int                     rr_idx;

  logic                   hold_vld_q;
  logic [IDX_W-1:0]       hold_idx_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [IDX_W-1:0]       fifo_q [OUTSTANDING];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic                   unexpected_q;

`ifdef ARB_LOCK_EN
  logic                   lock_vld_q;
  logic [IDX_W-1:0]       lock_idx_q;
`endif

  assign full  = (count_q == CNT_W'(OUTSTANDING));
  assign empty = (count_q == '0);
  assign head  = fifo_q[rd_ptr_q];

  always_comb begin
    req = '0;
    for (int m = 0; m < NUM_MASTERS; m++)
      req[m] = m_rd_i[m] | (|m_wr_i[m*4 +: 4]);
    elig = req;
`ifdef ARB_LOCK_EN
    // A lock stays in force only while its owner keeps m_lock_i high.
    if (lock_vld_q && m_lock_i[lock_idx_q])
      elig = req & (NUM_MASTERS'(1) << lock_idx_q);
`endif
  end

  // Descending scans let the lowest (or first-after-pointer) candidate win.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = 0;
    if (hold_vld_q && elig[hold_idx_q]) begin
      grant_vld = 1'b1;
      grant_idx = hold_idx_q;
    end else if (!mode_rr_i) begin
      for (int m = NUM_MASTERS - 1; m >= 0; m--) begin
        if (elig[m]) begin
          grant_vld = 1'b1;
          grant_idx = IDX_W'(m);
        end
      end
    end else begin
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
        rr_idx = (int'(rr_ptr_q) + k) % NUM_MASTERS;
        if (elig[rr_idx]) begin
          grant_vld = 1'b1;
          grant_idx = IDX_W'(rr_idx);
        end
      end
    end
  end

  always_comb begin
    issue         = grant_vld & ~full & ~rst_i;
    accept        = issue & mem_accept_i;
    pop           = mem_ack_i & ~empty & ~rst_i;
    mem_addr_o    = '0;
    mem_data_wr_o = '0;
    mem_rd_o      = 1'b0;
    mem_wr_o      = '0;
    mem_req_tag_o = '0;
    if (issue) begin
      mem_addr_o    = m_addr_i[grant_idx*32 +: 32];
      mem_data_wr_o = m_data_wr_i[grant_idx*32 +: 32];
      mem_rd_o      = m_rd_i[grant_idx];
      mem_wr_o      = m_wr_i[grant_idx*4 +: 4];
      mem_req_tag_o = m_tag_i[grant_idx*TAG_W +: TAG_W];
    end
    m_accept_o = accept ? (NUM_MASTERS'(1) << grant_idx) : '0;
    m_ack_o    = pop ? (NUM_MASTERS'(1) << head) : '0;
    m_error_o  = (pop && mem_error_i) ? (NUM_MASTERS'(1) << head) : '0;
  end

  assign m_data_rd_o      = mem_data_rd_i;
  assign m_resp_tag_o     = mem_resp_tag_i;
  assign outstanding_o    = count_q;
  assign unexpected_ack_o = unexpected_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_vld_q   <= 1'b0;
      hold_idx_q   <= '0;
      rr_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      unexpected_q <= 1'b0;
    end else begin
      if (issue) begin
        hold_vld_q <= ~mem_accept_i;
        hold_idx_q <= grant_idx;
      end else if (hold_vld_q && !req[hold_idx_q]) begin
        hold_vld_q <= 1'b0;
      end
      if (accept) begin
        rr_ptr_q <= (grant_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_idx + 1'b1;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (mem_ack_i && empty)
        unexpected_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept)
      fifo_q[wr_ptr_q] <= grant_idx;
  end

`ifdef ARB_LOCK_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
    end else if (accept && m_lock_i[grant_idx]) begin
      lock_vld_q <= 1'b1;
      lock_idx_q <= grant_idx;
    end else if (lock_vld_q && !m_lock_i[lock_idx_q]) begin
      lock_vld_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mem_d_arbiter.sv
// Scoreboard bench for mem_d_arbiter: directed stimulus pushes expected accepts/acks, a negedge monitor pops and compares.
module tb_mem_d_arbiter;
  localparam int NM = 3;
  localparam int TW = 11;
  localparam int OS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              mode_rr;
  logic [NM*32-1:0]  m_addr, m_data_wr;
  logic [NM-1:0]     m_rd;
  logic [NM*4-1:0]   m_wr;
  logic [NM*TW-1:0]  m_tag;
  logic [NM-1:0]     m_accept_o, m_ack_o, m_error_o;
  logic [31:0]       m_data_rd_o;
  logic [TW-1:0]     m_resp_tag_o;
  logic [31:0]       mem_addr_o, mem_data_wr_o;
  logic              mem_rd_o;
  logic [3:0]        mem_wr_o;
  logic [TW-1:0]     mem_req_tag_o;
  logic              mem_accept, mem_ack, mem_error;
  logic [31:0]       mem_data_rd;
  logic [TW-1:0]     mem_resp_tag;
  logic [$clog2(OS):0] outstanding_o;
  logic              unexpected_ack_o;

  mem_d_arbiter #(.NUM_MASTERS(NM), .TAG_W(TW), .OUTSTANDING(OS)) dut (
    .clk_i(clk), .rst_i(rst), .mode_rr_i(mode_rr),
    .m_addr_i(m_addr), .m_data_wr_i(m_data_wr), .m_rd_i(m_rd), .m_wr_i(m_wr), .m_tag_i(m_tag),
    .m_accept_o(m_accept_o), .m_ack_o(m_ack_o), .m_error_o(m_error_o),
    .m_data_rd_o(m_data_rd_o), .m_resp_tag_o(m_resp_tag_o),
    .mem_addr_o(mem_addr_o), .mem_data_wr_o(mem_data_wr_o), .mem_rd_o(mem_rd_o),
    .mem_wr_o(mem_wr_o), .mem_req_tag_o(mem_req_tag_o),
    .mem_accept_i(mem_accept), .mem_ack_i(mem_ack), .mem_error_i(mem_error),
    .mem_data_rd_i(mem_data_rd), .mem_resp_tag_i(mem_resp_tag),
    .outstanding_o(outstanding_o), .unexpected_ack_o(unexpected_ack_o)
  );

  typedef struct {int m; logic [31:0] addr; logic [TW-1:0] tag;} acc_t;
  typedef struct {int m; logic err; logic [31:0] data; logic [TW-1:0] tag;} ack_t;
  acc_t acc_q[$];
  ack_t ack_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [NM-1:0] v);
    for (int i = 0; i < NM; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    acc_t ea;
    ack_t ek;
    if (!rst) begin
      if (m_accept_o != '0) begin
        if (acc_q.size() == 0) chk("acc_unexpected", 64'(m_accept_o), 64'd0);
        else begin
          ea = acc_q.pop_front();
          chk("acc_onehot", 64'($onehot(m_accept_o)), 64'd1);
          chk("acc_master", 64'(onehot_idx(m_accept_o)), 64'(ea.m));
          chk("acc_addr", 64'(mem_addr_o), 64'(ea.addr));
          chk("acc_tag", 64'(mem_req_tag_o), 64'(ea.tag));
        end
      end
      if (m_ack_o != '0) begin
        if (ack_q.size() == 0) chk("ack_unexpected", 64'(m_ack_o), 64'd0);
        else begin
          ek = ack_q.pop_front();
          chk("ack_master", 64'(onehot_idx(m_ack_o)), 64'(ek.m));
          chk("ack_error", 64'(m_error_o), ek.err ? 64'(1 << ek.m) : 64'd0);
          chk("ack_data", 64'(m_data_rd_o), 64'(ek.data));
          chk("ack_tag", 64'(m_resp_tag_o), 64'(ek.tag));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic [31:0] addr, input logic [TW-1:0] tag);
    m_rd[m] = 1'b1;
    m_addr[m*32 +: 32] = addr;
    m_tag[m*TW +: TW] = tag;
  endtask

  task automatic exp_acc(input int m, input logic [31:0] addr, input logic [TW-1:0] tag);
    acc_q.push_back('{m: m, addr: addr, tag: tag});
  endtask

  task automatic do_ack(input int m, input logic err, input logic [31:0] data, input logic [TW-1:0] tag);
    ack_q.push_back('{m: m, err: err, data: data, tag: tag});
    mem_ack = 1'b1;
    mem_error = err;
    mem_data_rd = data;
    mem_resp_tag = tag;
    tick();
    mem_ack = 1'b0;
    mem_error = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mode_rr = 1'b0;
    m_addr = '0; m_data_wr = '0; m_rd = '0; m_wr = '0; m_tag = '0;
    mem_accept = 1'b1; mem_ack = 1'b0; mem_error = 1'b0;
    mem_data_rd = '0; mem_resp_tag = '0;
    tick(); tick();
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    chk("rst_unexpected", 64'(unexpected_ack_o), 64'd0);
    chk("rst_mem_rd", 64'(mem_rd_o), 64'd0);
    rst = 1'b0;
    tick();

    // Fixed priority: master 0 beats master 1
    set_req(0, 32'h8000_0010, 11'h010);
    set_req(1, 32'h8000_0020, 11'h020);
    exp_acc(0, 32'h8000_0010, 11'h010);
    tick();
    m_rd[0] = 1'b0;
    exp_acc(1, 32'h8000_0020, 11'h020);
    tick();
    m_rd[1] = 1'b0;
    #2 chk("fp_outstanding", 64'(outstanding_o), 64'd2);
    do_ack(0, 1'b0, 32'h1111, 11'h010);
    do_ack(1, 1'b0, 32'h2222, 11'h020);
    #2 chk("fp_drained", 64'(outstanding_o), 64'd0);

    // Round robin from pointer 0, wrapping 2 -> 0
    do_reset();
    mode_rr = 1'b1;
    for (int m = 0; m < NM; m++) set_req(m, 32'h9000_0000 + 32'(m), 11'(m + 1));
    for (int r = 0; r < 2; r++) begin
      for (int m = 0; m < NM; m++) begin
        exp_acc(m, 32'h9000_0000 + 32'(m), 11'(m + 1));
        tick();
      end
      m_rd = '0;
      for (int m = 0; m < NM; m++) do_ack(m, 1'b0, 32'h50 + 32'(m), 11'(m + 1));
      for (int m = 0; m < NM; m++) m_rd[m] = 1'b1;
    end
    m_rd = '0;
    mode_rr = 1'b0;

    // Held grant survives backpressure and a higher-priority request
    mem_accept = 1'b0;
    set_req(1, 32'h8000_0100, 11'h101);
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("hold_no_accept", 64'(m_accept_o), 64'd0);
      chk("hold_mem_addr", 64'(mem_addr_o), 64'h8000_0100);
      tick();
    end
    set_req(0, 32'h8000_0200, 11'h201);
    mem_accept = 1'b1;
    exp_acc(1, 32'h8000_0100, 11'h101);
    tick();
    m_rd[1] = 1'b0;
    exp_acc(0, 32'h8000_0200, 11'h201);
    tick();
    m_rd[0] = 1'b0;
    do_ack(1, 1'b0, 32'h3, 11'h101);
    do_ack(0, 1'b0, 32'h4, 11'h201);

    // FIFO full blocks issue, even alongside a pop
    set_req(0, 32'h0000_0400, 11'h044);
    for (int c = 0; c < 4; c++) begin
      exp_acc(0, 32'h0000_0400, 11'h044);
      tick();
    end
    #2;
    chk("full_outstanding", 64'(outstanding_o), 64'd4);
    chk("full_no_accept", 64'(m_accept_o), 64'd0);
    chk("full_mem_rd", 64'(mem_rd_o), 64'd0);
    tick();
    ack_q.push_back('{m: 0, err: 1'b0, data: 32'h77, tag: 11'h044});
    mem_ack = 1'b1; mem_data_rd = 32'h77; mem_resp_tag = 11'h044;
    #2 chk("full_pop_no_accept", 64'(m_accept_o), 64'd0);
    tick();
    mem_ack = 1'b0;
    exp_acc(0, 32'h0000_0400, 11'h044);
    tick();
    m_rd[0] = 1'b0;
    #2 chk("refill_outstanding", 64'(outstanding_o), 64'd4);
    for (int c = 0; c < 4; c++) do_ack(0, 1'b0, 32'h80 + 32'(c), 11'h044);

    // Interleaved 1,0,1 with an error on the middle response; master 0 issues a write
    set_req(1, 32'h8000_1000, 11'h7A1);
    exp_acc(1, 32'h8000_1000, 11'h7A1);
    tick();
    m_rd[1] = 1'b0;
    m_addr[0 +: 32] = 32'h8000_2000; m_tag[0 +: TW] = 11'h7B0;
    m_wr[3:0] = 4'h3; m_data_wr[31:0] = 32'hDEAD_BEEF;
    exp_acc(0, 32'h8000_2000, 11'h7B0);
    #2;
    chk("wr_mem_wr", 64'(mem_wr_o), 64'h3);
    chk("wr_mem_data", 64'(mem_data_wr_o), 64'hDEAD_BEEF);
    chk("wr_mem_rd", 64'(mem_rd_o), 64'd0);
    tick();
    m_wr[3:0] = 4'h0;
    set_req(1, 32'h8000_1004, 11'h7A2);
    exp_acc(1, 32'h8000_1004, 11'h7A2);
    tick();
    m_rd[1] = 1'b0;
    do_ack(1, 1'b0, 32'hA, 11'h7A1);
    do_ack(0, 1'b1, 32'hB, 11'h7B0);
    do_ack(1, 1'b0, 32'hC, 11'h7A2);
    #2 chk("il_drained", 64'(outstanding_o), 64'd0);

    // Ack with empty FIFO is dropped and flagged
    chk("unexp_clear", 64'(unexpected_ack_o), 64'd0);
    mem_ack = 1'b1;
    #2 chk("unexp_no_ack", 64'(m_ack_o), 64'd0);
    tick();
    mem_ack = 1'b0;
    tick(); tick();
    chk("unexp_sticky", 64'(unexpected_ack_o), 64'd1);

    // Reset with two in flight discards them
    set_req(2, 32'h8000_3000, 11'h333);
    exp_acc(2, 32'h8000_3000, 11'h333);
    tick();
    exp_acc(2, 32'h8000_3000, 11'h333);
    tick();
    #2 chk("pre_rst_outstanding", 64'(outstanding_o), 64'd2);
    rst = 1'b1;
    #1;
    chk("rst_mid_outstanding", 64'(outstanding_o), 64'd0);
    chk("rst_mid_unexpected", 64'(unexpected_ack_o), 64'd0);
    chk("rst_mid_accept", 64'(m_accept_o), 64'd0);
    chk("rst_mid_mem_rd", 64'(mem_rd_o), 64'd0);
    tick();
    m_rd = '0;
    rst = 1'b0;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #2 chk("late_ack_unexpected", 64'(unexpected_ack_o), 64'd1);
    tick();

    chk("acc_q_empty", 64'(acc_q.size()), 64'd0);
    chk("ack_q_empty", 64'(ack_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
